// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bundle of every handshake/bus signal of mem_arbiter.
//
// Groups:
//   fetch port : if_req, if_addr -> if_done, if_rdata
//   data port  : d_req, d_we, d_addr, d_wdata -> d_done, d_rdata
//   memory     : m_valid, m_we, m_addr, m_wdata -> m_ready, m_rvalid, m_rdata
//   status     : busy, conflict_cnt
//
// Modports:
//   slave  : the arbiter itself
//   master : the surrounding core/memory environment driving the arbiter
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [DATA_W-1:0] if_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;

    logic              m_valid;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ready;
    logic              m_rvalid;
    logic [DATA_W-1:0] m_rdata;

    logic              busy;
    logic [15:0]       conflict_cnt;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
               m_ready, m_rvalid, m_rdata,
        output if_done, if_rdata, d_done, d_rdata,
               m_valid, m_we, m_addr, m_wdata, busy, conflict_cnt
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
               m_ready, m_rvalid, m_rdata,
        input  if_done, if_rdata, d_done, d_rdata,
               m_valid, m_we, m_addr, m_wdata, busy, conflict_cnt
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- shares one memory port between an instruction-fetch
// requester and a data-stage requester.
//
// Ports:
//   clk      in  rising-edge clock
//   reset_n  in  asynchronous active-low reset
//   bus      mem_arbiter_if.slave (fetch port, data port, memory port, status)
//
// Operation: IDLE latches the winning request (owner, address, we, wdata),
// REQ presents it on the memory port until m_ready, RESP waits for m_rvalid
// and pulses the owner's done in that same cycle. m_addr is word aligned.
// conflict_cnt counts (saturating) the busy cycles in which the requester
// that is not being served is asking for the port.
//
// Configuration macro MEM_ARBITER_RR_EN:
//   undefined : data requester has fixed priority on simultaneous requests
//   defined   : round-robin via last_owner_q; resets to "instruction" so the
//               data requester wins the first collision
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP
    } state_t;

    // owner encoding: 1 = data requester, 0 = instruction fetch
    localparam logic OWN_DATA  = 1'b1;
    localparam logic OWN_INSTR = 1'b0;

    state_t            state_q;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              m_valid_q;
    logic              busy_q;
    logic [15:0]       conflict_cnt_q;
`ifdef MEM_ARBITER_RR_EN
    logic              last_owner_q;
`endif

    logic              grant_data;
    logic              any_req;
    logic              resp_fire;
    logic              other_waiting;

    assign any_req = bus.if_req | bus.d_req;

    always_comb begin
        grant_data = bus.d_req;
`ifdef MEM_ARBITER_RR_EN
        // On a collision the requester that was not served last wins.
        if (bus.d_req && bus.if_req) begin
            grant_data = (last_owner_q == OWN_INSTR);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_INSTR;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            m_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
            last_owner_q <= OWN_INSTR;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_q   <= grant_data;
                        addr_q    <= grant_data ? bus.d_addr : bus.if_addr;
                        we_q      <= grant_data & bus.d_we;
                        wdata_q   <= grant_data ? bus.d_wdata : '0;
                        m_valid_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_REQ;
`ifdef MEM_ARBITER_RR_EN
                        last_owner_q <= grant_data;
`endif
                    end
                end
                ST_REQ: begin
                    if (bus.m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (bus.m_rvalid) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    m_valid_q <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    // Only meaningful while busy; in IDLE the counter ignores it.
    assign other_waiting = (owner_q == OWN_DATA) ? bus.if_req : bus.d_req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_cnt_q <= '0;
        end else if (busy_q && other_waiting && (conflict_cnt_q != '1)) begin
            conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign resp_fire = (state_q == ST_RESP) && bus.m_rvalid;

    assign bus.if_done      = resp_fire && (owner_q == OWN_INSTR);
    assign bus.d_done       = resp_fire && (owner_q == OWN_DATA);
    assign bus.if_rdata     = bus.m_rdata;
    assign bus.d_rdata      = bus.m_rdata;

    assign bus.m_valid      = m_valid_q;
    assign bus.m_we         = we_q;
    assign bus.m_addr       = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.m_wdata      = wdata_q;

    assign bus.busy         = busy_q;
    assign bus.conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic clk;
    logic reset_n;
    int   total;
    int   bad;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        bus.if_req   = 1'b0;
        bus.if_addr  = '0;
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.d_addr   = '0;
        bus.d_wdata  = '0;
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b0;
        bus.m_rdata  = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Advance to just after the next rising edge (start of a new cycle).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        #3;
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rst_m_valid got=%0h exp=0", bus.m_valid); end
        total++; if (bus.m_we !== 1'b0) begin bad++; $display("FAIL rst_m_we got=%0h exp=0", bus.m_we); end
        total++; if (bus.m_addr !== 32'h0) begin bad++; $display("FAIL rst_m_addr got=%0h exp=0", bus.m_addr); end
        total++; if (bus.m_wdata !== 32'h0) begin bad++; $display("FAIL rst_m_wdata got=%0h exp=0", bus.m_wdata); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", bus.busy); end
        total++; if (bus.if_done !== 1'b0) begin bad++; $display("FAIL rst_if_done got=%0h exp=0", bus.if_done); end
        total++; if (bus.d_done !== 1'b0) begin bad++; $display("FAIL rst_d_done got=%0h exp=0", bus.d_done); end
        total++; if (bus.conflict_cnt !== 16'h0) begin bad++; $display("FAIL rst_cnt got=%0h exp=0", bus.conflict_cnt); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_single_fetch();
        do_reset();
        next_cycle();                         // cycle 0
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        @(negedge clk);
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL sf_c0_m_valid got=%0h exp=0", bus.m_valid); end
        next_cycle();                         // cycle 1
        bus.m_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL sf_c1_m_valid got=%0h exp=1", bus.m_valid); end
        total++; if (bus.m_addr !== 32'h100) begin bad++; $display("FAIL sf_c1_m_addr got=%0h exp=100", bus.m_addr); end
        total++; if (bus.m_we !== 1'b0) begin bad++; $display("FAIL sf_c1_m_we got=%0h exp=0", bus.m_we); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL sf_c1_busy got=%0h exp=1", bus.busy); end
        next_cycle();                         // cycle 2
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h00500093;
        @(negedge clk);
        total++; if (bus.if_done !== 1'b1) begin bad++; $display("FAIL sf_c2_if_done got=%0h exp=1", bus.if_done); end
        total++; if (bus.if_rdata !== 32'h00500093) begin bad++; $display("FAIL sf_c2_if_rdata got=%0h exp=00500093", bus.if_rdata); end
        total++; if (bus.d_done !== 1'b0) begin bad++; $display("FAIL sf_c2_d_done got=%0h exp=0", bus.d_done); end
        next_cycle();                         // cycle 3
        bus.if_req   = 1'b0;
        bus.m_rvalid = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sf_c3_busy got=%0h exp=0", bus.busy); end
        total++; if (bus.if_done !== 1'b0) begin bad++; $display("FAIL sf_c3_if_done got=%0h exp=0", bus.if_done); end
    endtask

    task automatic test_collision();
        do_reset();
        next_cycle();                         // cycle 0
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h2003;
        bus.d_wdata = 32'hAB;
        next_cycle();                         // cycle 1
        bus.m_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.m_addr !== 32'h2000) begin bad++; $display("FAIL col_d_m_addr got=%0h exp=2000", bus.m_addr); end
        total++; if (bus.m_we !== 1'b1) begin bad++; $display("FAIL col_d_m_we got=%0h exp=1", bus.m_we); end
        total++; if (bus.m_wdata !== 32'hAB) begin bad++; $display("FAIL col_d_m_wdata got=%0h exp=ab", bus.m_wdata); end
        next_cycle();                         // cycle 2
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b1;
        @(negedge clk);
        total++; if (bus.d_done !== 1'b1) begin bad++; $display("FAIL col_d_done got=%0h exp=1", bus.d_done); end
        total++; if (bus.if_done !== 1'b0) begin bad++; $display("FAIL col_if_done_early got=%0h exp=0", bus.if_done); end
        next_cycle();                         // cycle 3: back in IDLE, fetch latched at the end
        bus.d_req    = 1'b0;
        bus.d_we     = 1'b0;
        bus.m_rvalid = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL col_c3_busy got=%0h exp=0", bus.busy); end
        total++; if (bus.conflict_cnt !== 16'd2) begin bad++; $display("FAIL col_cnt got=%0d exp=2", bus.conflict_cnt); end
        next_cycle();                         // cycle 4
        bus.m_ready = 1'b1;
        @(negedge clk);
        total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL col_i_m_valid got=%0h exp=1", bus.m_valid); end
        total++; if (bus.m_addr !== 32'h300) begin bad++; $display("FAIL col_i_m_addr got=%0h exp=300", bus.m_addr); end
        total++; if (bus.m_we !== 1'b0) begin bad++; $display("FAIL col_i_m_we got=%0h exp=0", bus.m_we); end
        next_cycle();                         // cycle 5
        bus.m_ready  = 1'b0;
        bus.m_rvalid = 1'b1;
        bus.m_rdata  = 32'h12345678;
        @(negedge clk);
        total++; if (bus.if_done !== 1'b1) begin bad++; $display("FAIL col_i_done got=%0h exp=1", bus.if_done); end
        next_cycle();
        bus.if_req   = 1'b0;
        bus.m_rvalid = 1'b0;
        @(negedge clk);
        total++; if (bus.conflict_cnt !== 16'd2) begin bad++; $display("FAIL col_cnt_after got=%0d exp=2", bus.conflict_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_g [3];
        logic [31:0] seen  [3];
        int          got;
        exp_g[0] = 32'h2000;
`ifdef MEM_ARBITER_RR_EN
        exp_g[1] = 32'h300;
`else
        exp_g[1] = 32'h2000;
`endif
        exp_g[2] = 32'h2000;
        for (int i = 0; i < 3; i++) seen[i] = '0;
        got = 0;
        do_reset();
        next_cycle();
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h300;
        bus.d_req    = 1'b1;
        bus.d_addr   = 32'h2000;
        bus.m_ready  = 1'b1;
        bus.m_rvalid = 1'b1;
        for (int c = 0; c < 30 && got < 3; c++) begin
            @(negedge clk);
            if (bus.m_valid === 1'b1) begin
                seen[got] = bus.m_addr;
                got++;
            end
        end
        total++; if (got !== 3) begin bad++; $display("FAIL b2b_grant_count got=%0d exp=3", got); end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (seen[i] !== exp_g[i]) begin bad++; $display("FAIL b2b_grant%0d got=%0h exp=%0h", i, seen[i], exp_g[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        next_cycle();                         // cycle 0
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h444;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            bus.m_ready  = (c == 6);
            bus.m_rvalid = 1'b1;               // must be ignored outside RESP
            if (c == 3) bus.if_addr = 32'h888; // latched address must not follow
            @(negedge clk);
            total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL bp_m_valid c%0d got=%0h exp=1", c, bus.m_valid); end
            total++; if (bus.m_addr !== 32'h444) begin bad++; $display("FAIL bp_m_addr c%0d got=%0h exp=444", c, bus.m_addr); end
            total++; if (bus.if_done !== 1'b0) begin bad++; $display("FAIL bp_if_done c%0d got=%0h exp=0", c, bus.if_done); end
        end
        next_cycle();                         // cycle 7: RESP
        bus.m_ready  = 1'b0;
        bus.m_rdata  = 32'hCAFE0001;
        @(negedge clk);
        total++; if (bus.if_done !== 1'b1) begin bad++; $display("FAIL bp_done got=%0h exp=1", bus.if_done); end
        total++; if (bus.if_rdata !== 32'hCAFE0001) begin bad++; $display("FAIL bp_rdata got=%0h exp=cafe0001", bus.if_rdata); end
        next_cycle();
        bus.if_req   = 1'b0;
        bus.m_rvalid = 1'b0;
    endtask

    task automatic test_reset_midway();
        // reset while in REQ: m_valid must drop without a clock edge
        do_reset();
        next_cycle();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h40;
        next_cycle();                         // in REQ
        #1;
        total++; if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL rm_req_m_valid_pre got=%0h exp=1", bus.m_valid); end
        reset_n = 1'b0;
        #1;
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rm_req_m_valid got=%0h exp=0", bus.m_valid); end
        @(negedge clk);
        reset_n = 1'b1;
        bus.d_req = 1'b0;

        // reset while in RESP, then a stray m_rvalid must not complete anything
        next_cycle();
        bus.d_req = 1'b1;
        next_cycle();                         // REQ
        bus.m_ready = 1'b1;
        next_cycle();                         // RESP
        bus.m_ready = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rm_resp_busy_pre got=%0h exp=1", bus.busy); end
        reset_n      = 1'b0;
        bus.m_rvalid = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_resp_busy got=%0h exp=0", bus.busy); end
        total++; if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL rm_resp_m_valid got=%0h exp=0", bus.m_valid); end
        total++; if (bus.d_done !== 1'b0) begin bad++; $display("FAIL rm_resp_d_done got=%0h exp=0", bus.d_done); end
        bus.d_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            next_cycle();
            @(negedge clk);
            total++; if (bus.d_done !== 1'b0 || bus.if_done !== 1'b0) begin bad++; $display("FAIL rm_post_done c%0d got=%0h%0h exp=00", c, bus.d_done, bus.if_done); end
            total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_post_busy c%0d got=%0h exp=0", c, bus.busy); end
        end
        bus.m_rvalid = 1'b0;
    endtask

    task automatic test_saturation();
        do_reset();
        next_cycle();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        bus.d_req   = 1'b1;
        bus.d_addr  = 32'h200;
        bus.m_ready = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        // grant edge, then busy from cycle 1: 9 counted cycles so far
        total++; if (bus.conflict_cnt !== 16'd9) begin bad++; $display("FAIL sat_early got=%0d exp=9", bus.conflict_cnt); end
        repeat (70000) @(posedge clk);
        @(negedge clk);
        total++; if (bus.conflict_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_cnt got=%0h exp=ffff", bus.conflict_cnt); end
        repeat (20) @(posedge clk);
        @(negedge clk);
        total++; if (bus.conflict_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%0h exp=ffff", bus.conflict_cnt); end
        clear_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_fetch();
        test_collision();
        test_back_to_back();
        test_backpressure();
        test_reset_midway();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
